// File: rtl/mac_seq_pkg.sv
// mac_seq_pkg: shared definitions for the MAC sequencer.
//   - state_e      : sequencer state encoding (IDLE / RUN / RESULT)
//   - DEF_*        : default widths for the parameterised modules
//   - MUL_W        : width of the internal sign-extended multiply
//   - sext_mul()   : signed multiply of two already sign-extended operands
// Optional feature macro used by the design: MAC_SEQ_OVF_DETECT_EN.
package mac_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_RESULT = 2'd2
  } state_e;

  localparam int DEF_INPUT_WIDTH  = 8;
  localparam int DEF_OUTPUT_WIDTH = 32;
  localparam int DEF_LEN_WIDTH    = 8;

  // Operands are sign-extended to this width before multiplying; callers
  // truncate the product to the accumulator width, which gives the same
  // result modulo 2^OUTPUT_WIDTH as multiplying at OUTPUT_WIDTH directly.
  localparam int MUL_W = 64;

  function automatic logic [MUL_W-1:0] sext_mul(input logic signed [MUL_W-1:0] a,
                                                input logic signed [MUL_W-1:0] b);
    return a * b;
  endfunction

endpackage

// File: rtl/mac_seq_datapath.sv
// mac_seq_datapath: signed multiply-accumulate datapath.
// Ports:
//   clk, rst_n   : clock, asynchronous active-low reset
//   clear        : zero the accumulator (and overflow flag)
//   en           : accumulate a * b into the accumulator this cycle
//   a, b         : signed operands, INPUT_WIDTH bits
//   acc          : current accumulator value
//   sum          : acc + sext(a)*sext(b), i.e. the value acc takes when en=1
//   ovf          : sticky signed-add overflow (MAC_SEQ_OVF_DETECT_EN), else 0
// Sum wraps modulo 2^OUTPUT_WIDTH.
module mac_seq_datapath
  import mac_seq_pkg::*;
#(
  parameter int INPUT_WIDTH  = DEF_INPUT_WIDTH,
  parameter int OUTPUT_WIDTH = DEF_OUTPUT_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clear,
  input  logic                    en,
  input  logic [INPUT_WIDTH-1:0]  a,
  input  logic [INPUT_WIDTH-1:0]  b,
  output logic [OUTPUT_WIDTH-1:0] acc,
  output logic [OUTPUT_WIDTH-1:0] sum,
  output logic                    ovf
);

  logic [MUL_W-1:0]        a_ext;
  logic [MUL_W-1:0]        b_ext;
  logic [OUTPUT_WIDTH-1:0] prod;
  logic [OUTPUT_WIDTH-1:0] sum_w;
  logic [OUTPUT_WIDTH-1:0] acc_d, acc_q;

  assign a_ext = {{(MUL_W-INPUT_WIDTH){a[INPUT_WIDTH-1]}}, a};
  assign b_ext = {{(MUL_W-INPUT_WIDTH){b[INPUT_WIDTH-1]}}, b};
  assign prod  = OUTPUT_WIDTH'(sext_mul(a_ext, b_ext));
  assign sum_w = acc_q + prod;

  always_comb begin
    acc_d = acc_q;
    if (clear)   acc_d = '0;
    else if (en) acc_d = sum_w;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_d;
  end

`ifdef MAC_SEQ_OVF_DETECT_EN
  logic ovf_set;
  logic ovf_d, ovf_q;

  // Signed add overflow: both addends share a sign but the sum does not.
  assign ovf_set = (acc_q[OUTPUT_WIDTH-1] == prod[OUTPUT_WIDTH-1]) &&
                   (sum_w[OUTPUT_WIDTH-1] != acc_q[OUTPUT_WIDTH-1]);

  always_comb begin
    ovf_d = ovf_q;
    if (clear)   ovf_d = 1'b0;
    else if (en) ovf_d = ovf_q | ovf_set;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovf_q <= 1'b0;
    else        ovf_q <= ovf_d;
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

  assign acc = acc_q;
  assign sum = sum_w;

endmodule

// File: rtl/mac_sequencer.sv
// mac_sequencer: job controller around a signed MAC datapath.
// A start in IDLE latches cfg_len, clears the accumulator and consumes that
// many operand pairs; the final sum is offered on the result port.
// Ports:
//   clk, rst_n               : clock, asynchronous active-low reset
//   start, abort, cfg_len    : job control (abort wins over everything)
//   in_valid/in_ready, data_in_1/data_in_2 : operand stream
//   out_valid/out_ready, data_out          : result stream
//   busy                     : state != IDLE
//   ovf                      : sticky overflow (MAC_SEQ_OVF_DETECT_EN), else 0
//   state_dbg                : current FSM state, for observation only
// Handshake rule: a transfer happens on a rising edge where valid and ready
// are both high; in_ready/out_valid are registered and never depend
// combinationally on in_valid/out_ready, and a raised valid holds its data
// until accepted.
// Optional feature macro: MAC_SEQ_OVF_DETECT_EN.
module mac_sequencer
  import mac_seq_pkg::*;
#(
  parameter int INPUT_WIDTH  = DEF_INPUT_WIDTH,
  parameter int OUTPUT_WIDTH = DEF_OUTPUT_WIDTH,
  parameter int LEN_WIDTH    = DEF_LEN_WIDTH
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic                    abort,
  input  logic [LEN_WIDTH-1:0]    cfg_len,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [INPUT_WIDTH-1:0]  data_in_1,
  input  logic [INPUT_WIDTH-1:0]  data_in_2,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OUTPUT_WIDTH-1:0] data_out,
  output logic                    busy,
  output logic                    ovf,
  output state_e                  state_dbg
);

  state_e                  state_d, state_q;
  logic [LEN_WIDTH-1:0]    len_d, len_q;
  logic [LEN_WIDTH-1:0]    count_d, count_q;
  logic [OUTPUT_WIDTH-1:0] data_out_d, data_out_q;
  logic                    in_ready_d, in_ready_q;
  logic                    out_valid_d, out_valid_q;
  logic                    busy_d, busy_q;
  logic                    hs;
  logic                    dp_clear, dp_en;
  logic [OUTPUT_WIDTH-1:0] dp_acc, dp_sum;

  assign hs = in_valid & in_ready_q;

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    count_d     = count_q;
    data_out_d  = data_out_q;
    in_ready_d  = in_ready_q;
    out_valid_d = out_valid_q;
    busy_d      = busy_q;
    dp_clear    = 1'b0;
    dp_en       = 1'b0;
    if (abort) begin
      // data_out keeps its last value; an aborted job produces no result.
      state_d     = ST_IDLE;
      in_ready_d  = 1'b0;
      out_valid_d = 1'b0;
      busy_d      = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            len_d    = cfg_len;
            count_d  = '0;
            dp_clear = 1'b1;
            busy_d   = 1'b1;
            if (cfg_len == '0) begin
              state_d     = ST_RESULT;
              data_out_d  = '0;
              out_valid_d = 1'b1;
            end else begin
              state_d    = ST_RUN;
              in_ready_d = 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (hs) begin
            dp_en   = 1'b1;
            count_d = count_q + LEN_WIDTH'(1);
            if (count_q == len_q - LEN_WIDTH'(1)) begin
              // Last pair: capture the sum including this product.
              data_out_d  = dp_sum;
              state_d     = ST_RESULT;
              in_ready_d  = 1'b0;
              out_valid_d = 1'b1;
            end
          end
        end
        ST_RESULT: begin
          if (out_ready) begin
            state_d     = ST_IDLE;
            out_valid_d = 1'b0;
            busy_d      = 1'b0;
          end
        end
        default: begin
          state_d     = ST_IDLE;
          in_ready_d  = 1'b0;
          out_valid_d = 1'b0;
          busy_d      = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      count_q     <= '0;
      data_out_q  <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      count_q     <= count_d;
      data_out_q  <= data_out_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  mac_seq_datapath #(
    .INPUT_WIDTH  (INPUT_WIDTH),
    .OUTPUT_WIDTH (OUTPUT_WIDTH)
  ) u_datapath (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (dp_clear),
    .en    (dp_en),
    .a     (data_in_1),
    .b     (data_in_2),
    .acc   (dp_acc),
    .sum   (dp_sum),
    .ovf   (ovf)
  );

  // The accumulator value itself is only needed through dp_sum.
  logic unused_acc;
  assign unused_acc = ^dp_acc;

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign data_out  = data_out_q;
  assign busy      = busy_q;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_mac_sequencer.sv
// tb_mac_sequencer: self-checking bench for mac_sequencer.
// Build with MAC_SEQ_OVF_DETECT_EN defined to exercise the overflow flag
// (the bench then uses a 16-bit accumulator).
module tb_mac_sequencer;
  import mac_seq_pkg::*;

  localparam int IW = 8;
  localparam int LW = 8;
`ifdef MAC_SEQ_OVF_DETECT_EN
  localparam int OW     = 16;
  localparam bit OVF_ON = 1'b1;
`else
  localparam int OW     = 32;
  localparam bit OVF_ON = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0, abort = 1'b0;
  logic [LW-1:0] cfg_len = '0;
  logic          in_valid = 1'b0, in_ready;
  logic [IW-1:0] data_in_1 = '0, data_in_2 = '0;
  logic          out_valid, out_ready = 1'b0;
  logic [OW-1:0] data_out;
  logic          busy, ovf;
  state_e        state_dbg;

  always #5 clk = ~clk;

  mac_sequencer #(.INPUT_WIDTH(IW), .OUTPUT_WIDTH(OW), .LEN_WIDTH(LW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .cfg_len(cfg_len),
    .in_valid(in_valid), .in_ready(in_ready), .data_in_1(data_in_1),
    .data_in_2(data_in_2), .out_valid(out_valid), .out_ready(out_ready),
    .data_out(data_out), .busy(busy), .ovf(ovf), .state_dbg(state_dbg)
  );

  // ---------------- scoreboard ----------------
  int errors = 0;
  int checks = 0;
  logic [IW-1:0] qa[$];
  logic [IW-1:0] qb[$];
  logic [OW-1:0] exp_q[$];
  logic [OW-1:0] last_result = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: dot product with plain integer arithmetic, wrapped into the
  // OW-bit signed range after every add; overflow when the exact add leaves it.
  task automatic model(input int len, output logic [OW-1:0] res, output logic ovf_o);
    longint acc, p, lim;
    lim = longint'(1) <<< (OW - 1);
    acc = 0;
    ovf_o = 1'b0;
    for (int k = 0; k < len; k++) begin
      p = longint'($signed(qa[k])) * longint'($signed(qb[k]));
      acc = acc + p;
      if (acc >= lim) begin acc = acc - 2 * lim; ovf_o = 1'b1; end
      if (acc < -lim) begin acc = acc + 2 * lim; ovf_o = 1'b1; end
    end
    res = OW'(acc);
  endtask

  // ---------------- drivers ----------------
  task automatic start_job(input int len);
    cfg_len = LW'(len);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // Performs n back-to-back handshakes using qa/qb from index 0.
  task automatic feed(input int n);
    for (int k = 0; k < n; k++) begin
      in_valid = 1'b1; data_in_1 = qa[k]; data_in_2 = qb[k];
      check("feed_in_ready", 64'(in_ready), 64'(1));
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  // Full job using qa/qb; exp is the required result.
  task automatic run_job(input int len, input logic [OW-1:0] exp, input int gap_pct,
                         input int hold, input bit pulse_start);
    logic [OW-1:0] m_res;
    logic          m_ovf;
    int            i, cyc;
    bit            hs;
    model(len, m_res, m_ovf);
    exp_q.push_back(exp);
    start_job(len);
    check("busy_after_start", 64'(busy), 64'(1));
    check("ovf_cleared_on_start", 64'(ovf), 64'(0));
    if (len > 0) begin
      check("in_ready_run", 64'(in_ready), 64'(1));
      check("out_valid_run", 64'(out_valid), 64'(0));
    end
    i = 0; cyc = 0;
    while (i < len && cyc < 2000) begin
      in_valid  = ($urandom_range(0, 99) >= gap_pct);
      data_in_1 = qa[i];
      data_in_2 = qb[i];
      hs = in_valid && in_ready;
      @(posedge clk); #1;
      cyc++;
      if (hs) i++;
    end
    in_valid = 1'b0;
    check("operands_consumed", 64'(i), 64'(len));
    // Exactly one cycle after the last handshake (or after start for len=0).
    check("out_valid_latency", 64'(out_valid), 64'(1));
    check("in_ready_in_result", 64'(in_ready), 64'(0));
    check("data_out", 64'(data_out), 64'(exp_q[0]));
    check("ovf_at_result", 64'(ovf), 64'(m_ovf & OVF_ON));
    for (int h = 0; h < hold; h++) begin
      if (pulse_start && h == 1) begin cfg_len = LW'(5); start = 1'b1; end
      @(posedge clk); #1;
      start = 1'b0;
      check("hold_out_valid", 64'(out_valid), 64'(1));
      check("hold_data_out", 64'(data_out), 64'(exp_q[0]));
      check("hold_in_ready", 64'(in_ready), 64'(0));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("out_valid_after_accept", 64'(out_valid), 64'(0));
    check("busy_after_accept", 64'(busy), 64'(0));
    check("state_idle_after_accept", 64'(state_dbg), 64'(ST_IDLE));
    @(posedge clk); #1;
    check("no_second_result", 64'(out_valid), 64'(0));
    check("data_out_retained", 64'(data_out), 64'(exp_q[0]));
    last_result = exp_q.pop_front();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int     len;
    int     a[4];
    int     b[4];
    longint exp;
    int     gap;
    int     hold;
    bit     pulse;
  } vec_t;

  vec_t tbl[$];

  task automatic add_vec(input int len, input int a0, input int b0, input int a1,
                         input int b1, input int a2, input int b2, input longint exp,
                         input int gap, input int hold, input bit pulse);
    vec_t v;
    v.len = len;
    v.a[0] = a0; v.a[1] = a1; v.a[2] = a2; v.a[3] = 0;
    v.b[0] = b0; v.b[1] = b1; v.b[2] = b2; v.b[3] = 0;
    v.exp = exp; v.gap = gap; v.hold = hold; v.pulse = pulse;
    tbl.push_back(v);
  endtask

  task automatic load_pairs(input vec_t v);
    qa.delete(); qb.delete();
    for (int k = 0; k < v.len; k++) begin
      qa.push_back(IW'(v.a[k]));
      qb.push_back(IW'(v.b[k]));
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_data_out"}, 64'(data_out), 64'(0));
    check({tag, "_out_valid"}, 64'(out_valid), 64'(0));
    check({tag, "_in_ready"}, 64'(in_ready), 64'(0));
    check({tag, "_busy"}, 64'(busy), 64'(0));
    check({tag, "_ovf"}, 64'(ovf), 64'(0));
    check({tag, "_state"}, 64'(state_dbg), 64'(ST_IDLE));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "timeout");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [OW-1:0] m_res;
    logic          m_ovf;
    int            len;

    add_vec(3, 2, 3, -4, 5, 127, -128, -16270, 0, 0, 1'b0);
    add_vec(0, 0, 0, 0, 0, 0, 0, 0, 0, 2, 1'b0);
    add_vec(2, -128, -128, -128, -128, 0, 0, 32768, 0, 0, 1'b0);
    add_vec(1, 7, -9, 0, 0, 0, 0, -63, 0, 1, 1'b0);
    add_vec(2, 100, 3, -50, 2, 0, 0, 200, 75, 5, 1'b1);

    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Table-driven jobs.
    foreach (tbl[n]) begin
      load_pairs(tbl[n]);
      run_job(tbl[n].len, OW'(tbl[n].exp), tbl[n].gap, tbl[n].hold, tbl[n].pulse);
    end

    // Reset in the middle of a job, then a fresh job.
    qa = '{IW'(3), IW'(4), IW'(5), IW'(6)};
    qb = '{IW'(1), IW'(1), IW'(1), IW'(1)};
    start_job(4);
    feed(2);
    rst_n = 1'b0;
    #1;
    check_reset_values("midjob_reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    qa = '{IW'(5)}; qb = '{IW'(5)};
    run_job(1, OW'(25), 0, 0, 1'b0);

    // Abort coincident with the 3rd handshake.
    qa = '{IW'(9), IW'(9), IW'(9), IW'(9)};
    qb = '{IW'(9), IW'(9), IW'(9), IW'(9)};
    start_job(4);
    feed(2);
    in_valid = 1'b1; abort = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; abort = 1'b0; start = 1'b0;
    check("abort_state", 64'(state_dbg), 64'(ST_IDLE));
    check("abort_in_ready", 64'(in_ready), 64'(0));
    check("abort_busy", 64'(busy), 64'(0));
    check("abort_data_out_kept", 64'(data_out), 64'(last_result));
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      check("abort_no_result", 64'(out_valid), 64'(0));
    end
    qa = '{IW'(-1)}; qb = '{IW'(-1)};
    run_job(1, OW'(1), 0, 0, 1'b0);

    // Randomised jobs against the reference model.
    for (int r = 0; r < 25; r++) begin
      len = (r % 8 == 7) ? 0 : int'($urandom_range(1, 9));
      qa.delete(); qb.delete();
      for (int k = 0; k < len; k++) begin
        qa.push_back(IW'($urandom));
        qb.push_back(IW'($urandom));
      end
      model(len, m_res, m_ovf);
      run_job(len, m_res, int'($urandom_range(0, 50)), int'($urandom_range(0, 3)),
              1'($urandom_range(0, 1)));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
